// File: rtl/barrel_shift_sequencer_if.sv
// Command / shifter / result bundle for barrel_shift_sequencer.
// res_zero exists only when SHIFT_SEQ_ZERO_FLAG_EN is defined.
interface barrel_shift_sequencer_if #(
  parameter int AMT_W = 4
);
  // valid/ready: a transfer occurs on a rising clk edge where valid && ready.
  // The producer holds its payload stable while valid=1 and ready=0.
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_select;
  logic             cmd_direction;
  logic [AMT_W-1:0] cmd_amount;
  logic [3:0]       cmd_data;

  logic             sh_select;
  logic             sh_direction;
  logic [1:0]       sh_shift_value;
  logic [3:0]       sh_din;
  logic [3:0]       sh_dout;

  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_data;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  logic             res_zero;
`endif

  modport master (
    input  cmd_valid, cmd_select, cmd_direction, cmd_amount, cmd_data,
    input  sh_dout, res_ready,
    output cmd_ready, sh_select, sh_direction, sh_shift_value, sh_din,
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    output res_zero,
`endif
    output res_valid, res_data
  );

  modport slave (
    output cmd_valid, cmd_select, cmd_direction, cmd_amount, cmd_data,
    output sh_dout, res_ready,
    input  cmd_ready, sh_select, sh_direction, sh_shift_value, sh_din,
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    input  res_zero,
`endif
    input  res_valid, res_data
  );
endinterface

// File: rtl/barrel_shift_sequencer.sv
// Splits a shift/rotate command into passes of at most 3 through an external
// 4-bit barrel shifter. Optional res_zero flag: define SHIFT_SEQ_ZERO_FLAG_EN.
module barrel_shift_sequencer #(
  parameter int AMT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  barrel_shift_sequencer_if.master     bus,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       work;
  logic [AMT_W-1:0] remaining;
  logic             sel_q;
  logic             dir_q;

  logic [AMT_W+1:0] rem_wide;
  logic [1:0]       step;
  logic [AMT_W-1:0] rem_next;

  // Widened copy keeps the min(remaining,3) compare legal for any AMT_W.
  always_comb begin
    rem_wide = {2'b00, remaining};
    step     = (rem_wide >= (AMT_W+2)'(3)) ? 2'd3 : rem_wide[1:0];
    rem_next = remaining - AMT_W'(step);
  end

  always_comb begin
    bus.cmd_ready      = (state == IDLE);
    bus.sh_select      = sel_q;
    bus.sh_direction   = dir_q;
    bus.sh_din         = work;
    bus.sh_shift_value = (state == RUN) ? step : 2'd0;
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      work          <= 4'd0;
      remaining     <= '0;
      sel_q         <= 1'b0;
      dir_q         <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= 4'd0;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
      bus.res_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            sel_q     <= bus.cmd_select;
            dir_q     <= bus.cmd_direction;
            work      <= bus.cmd_data;
            remaining <= bus.cmd_amount;
            state     <= RUN;
          end
        end
        RUN: begin
          // Amount 0 still makes one pass, so the exit test follows the update.
          work      <= bus.sh_dout;
          remaining <= rem_next;
          if (rem_next == '0) begin
            state         <= DONE;
            bus.res_valid <= 1'b1;
            bus.res_data  <= bus.sh_dout;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
            bus.res_zero  <= (bus.sh_dout == 4'b0000);
`endif
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Directed bench for barrel_shift_sequencer with a behavioural 4-bit shifter
// closing the sh_* loop.
module tb_barrel_shift_sequencer;

  localparam int AMT_W = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         pass_cnt;
  int         total_cnt;

  barrel_shift_sequencer_if #(.AMT_W(AMT_W)) bus ();

  barrel_shift_sequencer #(.AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- shifter model ----------------
  function automatic logic [3:0] shifter(input logic sel, input logic dir,
                                         input logic [1:0] sv, input logic [3:0] d);
    logic [7:0] dd;
    dd = {d, d};
    if (!sel) return dir ? (d << sv) : (d >> sv);
    if (dir) begin
      dd = dd << sv;
      return dd[7:4];
    end
    dd = dd >> sv;
    return dd[3:0];
  endfunction

  always_comb bus.sh_dout = shifter(bus.sh_select, bus.sh_direction,
                                    bus.sh_shift_value, bus.sh_din);

  // ---------------- driver tasks ----------------
  // Entered just after a negedge; returns at the negedge after the accept edge.
  task automatic send_cmd(input logic sel, input logic dir,
                          input logic [AMT_W-1:0] amt, input logic [3:0] data);
    bus.cmd_select    = sel;
    bus.cmd_direction = dir;
    bus.cmd_amount    = amt;
    bus.cmd_data      = data;
    bus.cmd_valid     = 1'b1;
    @(negedge clk);
    bus.cmd_valid     = 1'b0;
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b exp 1", bus.cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b exp 0", bus.res_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.res_data !== 4'b0000) $display("FAIL reset_res_data: got %b exp 0000", bus.res_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.sh_shift_value !== 2'b00) $display("FAIL reset_shift_value: got %b exp 00", bus.sh_shift_value);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_rotate_left_1();
    send_cmd(1'b1, 1'b1, 4'd1, 4'b1001);
    total_cnt++;
    if (bus.sh_shift_value !== 2'b01 || bus.sh_din !== 4'b1001)
      $display("FAIL rol1_pass: got sv=%b din=%b exp sv=01 din=1001", bus.sh_shift_value, bus.sh_din);
    else pass_cnt++;
    total_cnt++;
    if (bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b0)
      $display("FAIL rol1_busy: got ready=%b valid=%b exp 0 0", bus.cmd_ready, bus.res_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b0011)
      $display("FAIL rol1_result: got valid=%b data=%b exp 1 0011", bus.res_valid, bus.res_data);
    else pass_cnt++;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    total_cnt++;
    if (bus.res_zero !== 1'b0) $display("FAIL rol1_zero: got %b exp 0", bus.res_zero);
    else pass_cnt++;
`endif
    take_result();
    total_cnt++;
    if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0)
      $display("FAIL rol1_idle: got ready=%b valid=%b exp 1 0", bus.cmd_ready, bus.res_valid);
    else pass_cnt++;
  endtask

  task automatic test_shift_right_5();
    logic [1:0] exp_sv [2];
    logic [3:0] exp_din [2];
    exp_sv  = '{2'b11, 2'b10};
    exp_din = '{4'b1011, 4'b0001};
    send_cmd(1'b0, 1'b0, 4'd5, 4'b1011);
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (bus.sh_shift_value !== exp_sv[i] || bus.sh_din !== exp_din[i] || bus.res_valid !== 1'b0)
        $display("FAIL shr5_pass%0d: got sv=%b din=%b valid=%b exp sv=%b din=%b valid=0",
                 i, bus.sh_shift_value, bus.sh_din, bus.res_valid, exp_sv[i], exp_din[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b0000)
      $display("FAIL shr5_result: got valid=%b data=%b exp 1 0000", bus.res_valid, bus.res_data);
    else pass_cnt++;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    total_cnt++;
    if (bus.res_zero !== 1'b1) $display("FAIL shr5_zero: got %b exp 1", bus.res_zero);
    else pass_cnt++;
`endif
    take_result();
  endtask

  task automatic test_rotate_right_7();
    logic [1:0] exp_sv [3];
    logic [3:0] exp_din [3];
    exp_sv  = '{2'b11, 2'b11, 2'b01};
    exp_din = '{4'b0001, 4'b0010, 4'b0100};
    send_cmd(1'b1, 1'b0, 4'd7, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (bus.sh_shift_value !== exp_sv[i] || bus.sh_din !== exp_din[i] || bus.res_valid !== 1'b0)
        $display("FAIL ror7_pass%0d: got sv=%b din=%b valid=%b exp sv=%b din=%b valid=0",
                 i, bus.sh_shift_value, bus.sh_din, bus.res_valid, exp_sv[i], exp_din[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b0010)
      $display("FAIL ror7_result: got valid=%b data=%b exp 1 0010", bus.res_valid, bus.res_data);
    else pass_cnt++;
    take_result();
  endtask

  task automatic test_back_to_back();
    send_cmd(1'b0, 1'b1, 4'd0, 4'b0111);
    total_cnt++;
    if (bus.sh_shift_value !== 2'b00 || bus.sh_din !== 4'b0111)
      $display("FAIL amt0_pass: got sv=%b din=%b exp sv=00 din=0111", bus.sh_shift_value, bus.sh_din);
    else pass_cnt++;
    // A stray command during DONE must be ignored.
    bus.cmd_select = 1'b1; bus.cmd_direction = 1'b0; bus.cmd_amount = 4'd9; bus.cmd_data = 4'b1010;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b0111 || bus.cmd_ready !== 1'b0)
        $display("FAIL amt0_hold%0d: got valid=%b data=%b ready=%b exp 1 0111 0",
                 i, bus.res_valid, bus.res_data, bus.cmd_ready);
      else pass_cnt++;
    end
    bus.cmd_valid = 1'b0;
    take_result();
    total_cnt++;
    if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0)
      $display("FAIL amt0_idle: got ready=%b valid=%b exp 1 0", bus.cmd_ready, bus.res_valid);
    else pass_cnt++;
    send_cmd(1'b0, 1'b1, 4'd2, 4'b0111);
    total_cnt++;
    if (bus.sh_shift_value !== 2'b10 || bus.sh_din !== 4'b0111)
      $display("FAIL shl2_pass: got sv=%b din=%b exp sv=10 din=0111", bus.sh_shift_value, bus.sh_din);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b1100)
      $display("FAIL shl2_result: got valid=%b data=%b exp 1 1100", bus.res_valid, bus.res_data);
    else pass_cnt++;
    take_result();
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] exp_din [3];
    int seen_valid;
    exp_din = '{4'b1000, 4'b0100, 4'b0010};
    send_cmd(1'b1, 1'b1, 4'd15, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (bus.sh_shift_value !== 2'b11 || bus.sh_din !== exp_din[i])
        $display("FAIL rol15_pass%0d: got sv=%b din=%b exp sv=11 din=%b",
                 i, bus.sh_shift_value, bus.sh_din, exp_din[i]);
      else pass_cnt++;
      if (i < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (dbg_state !== 2'd0 || bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0)
      $display("FAIL abort_idle: got state=%0d ready=%b valid=%b exp 0 1 0",
               dbg_state, bus.cmd_ready, bus.res_valid);
    else pass_cnt++;
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) seen_valid++;
    end
    total_cnt++;
    if (seen_valid != 0) $display("FAIL abort_no_result: got %0d valid cycles exp 0", seen_valid);
    else pass_cnt++;
    send_cmd(1'b1, 1'b1, 4'd15, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (bus.sh_shift_value !== 2'b11 || bus.res_valid !== 1'b0)
        $display("FAIL rol15_full_pass%0d: got sv=%b valid=%b exp sv=11 valid=0",
                 i, bus.sh_shift_value, bus.res_valid);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b0100)
      $display("FAIL rol15_result: got valid=%b data=%b exp 1 0100", bus.res_valid, bus.res_data);
    else pass_cnt++;
    take_result();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pass_cnt          = 0;
    total_cnt         = 0;
    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_select    = 1'b0;
    bus.cmd_direction = 1'b0;
    bus.cmd_amount    = '0;
    bus.cmd_data      = 4'd0;
    bus.res_ready     = 1'b0;
    @(negedge clk);
    test_reset();
    test_rotate_left_1();
    test_shift_right_5();
    test_rotate_right_7();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/barrel_shift_sequencer.md
Name: barrel_shift_sequencer

Overview:
Command-driven controller placed directly upstream of the 4-bit barrel_shifter. It feeds the shifter's select, direction, shift_value and din inputs, and consumes its dout.
- Accepts a shift/rotate command with a 0..(2^AMT_W-1) amount over valid/ready.
- Breaks the amount into passes of at most 3 bits and feeds each pass result back in as the next din.
- Returns the final 4-bit result over valid/ready.

Parameters:
AMT_W, 4, width of the requested shift/rotate amount (max amount 2^AMT_W-1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_select  input  1  0 = shift (zero fill), 1 = rotate
cmd_direction  input  1  0 = right, 1 = left
cmd_amount  input  AMT_W  total bit positions to move
cmd_data  input  4  operand
sh_select  output  1  to shifter select
sh_direction  output  1  to shifter direction
sh_shift_value  output  2  to shifter shift_value
sh_din  output  4  to shifter din
sh_dout  input  4  from shifter dout (combinational return, same cycle)
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  4  final result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a rising edge: state<=IDLE, res_valid=0, res_data=0, work=0, remaining=0, latched select/direction=0.
- Consequence of reset: cmd_ready=1 in the first cycle after reset.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch select, direction, work<=cmd_data and remaining<=cmd_amount, then go to RUN.
  - cmd_valid while not in IDLE is ignored; cmd_* inputs are not sampled.
- RUN, once per cycle:
  - step = min(remaining, 3).
  - Drive sh_shift_value=step, sh_din=work, sh_select/sh_direction = latched values.
  - At the clock edge: work<=sh_dout, remaining<=remaining-step.
  - If remaining-step==0, go to DONE and res_data<=sh_dout.
- Pass count:
  - amount 0 takes exactly one pass with shift_value=0 (data unchanged).
  - In general, passes P = max(1, ceil(amount/3)). Example: amount 15 gives 5 passes (3,3,3,3,3).
- Latency: a command accepted at edge N gives res_valid=1 after edge N+P; no bubble between passes.
- Outputs outside RUN: sh_shift_value=0, sh_din=work, sh_select/sh_direction hold latched values.
- DONE:
  - res_valid=1; res_data is stable and unchanged while res_ready=0, for unlimited backpressure.
  - On res_valid&&res_ready, go to IDLE and res_valid<=0.
  - cmd_ready stays 0 in DONE, so a new command is accepted no earlier than the cycle after the result handshake.
- Arithmetic:
  - Shift mode: any amount >=4 yields 0000, reached naturally by iteration; no shortcut.
  - Rotate mode: the result equals rotation by amount mod 4.
- Reset mid-RUN or mid-DONE: abort immediately and reach IDLE state next cycle. No res_valid is produced for the aborted command.
- sh_dout is treated as purely combinational from the sh_* outputs; the sequencer adds no register between them.

Optional Feature:
SHIFT_SEQ_ZERO_FLAG_EN
- Defined: adds output res_zero (1 bit).
  - Registered together with res_data: res_zero<=(sh_dout==4'b0000) on the final pass.
  - Reset value 0; valid when res_valid=1 and held under backpressure.
- Undefined: port absent, no extra logic.

Test Plan:
- Reset then IDLE: hold rst=1 for 2 cycles, release -> cmd_ready=1, res_valid=0, res_data=0000, sh_shift_value=00.
- Rotate left 1 of 1001 (select=1, dir=1, amount=1) -> one RUN cycle with sh_shift_value=01, res_valid after 1 edge, res_data=0011.
- Shift right 5 of 1011 (select=0, dir=0) -> passes with shift_value 11 then 10, res_valid after 2 edges, res_data=0000 (res_zero=1 if enabled).
- Rotate right 7 of 0001 -> passes 11,11,01, res_valid after 3 edges, res_data=0010.
- Amount 0 with backpressure: shift left 0 of 0111 with res_ready=0 for 4 cycles -> one pass with shift_value=00, res_data=0111 held stable, cmd_ready=0 throughout. Then res_ready=1 -> IDLE next cycle, and a back-to-back shift left 2 of 0111 yields 1100.
- Reset mid-operation: rotate left 15 of 1000, assert rst on the 3rd RUN cycle -> IDLE next cycle, res_valid never asserted, a subsequent command completes normally.
